cgra_config_readback: RTL
=========================

CGRA_CONFIG_READBACK -- requirements
Module: cgra_config_readback

Interface
REQ-001 SHALL have parameter BITSTREAM_LENGTH, default 1024, number of payload bits to capture (>=1).
REQ-002 SHALL have parameter CHAIN_DELAY, default 0, number of enabled cycles discarded before the first payload bit.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, word FIFO entries (power of two, >=2).
REQ-004 SHALL have parameter EXPECTED_CRC, default 16'h0000, reference CRC; exists only under CFG_READBACK_CRC_EN.
REQ-005 SHALL have one clock and a synchronous active-high reset: clock  in  1  rising-edge clock (driven from Config_Clock).
REQ-006 sync_reset  in  1  synchronous active-high reset.
REQ-007 enable  in  1  sample qualifier; no bit consumed, no counter advanced while low.
REQ-008 bitstream  in  1  serial readback data (from cgra ConfigOut).
REQ-009 word_data  out  32  head-of-FIFO word.
REQ-010 word_valid  out  1  FIFO non-empty.
REQ-011 word_ready  in  1  consumer accepts head word when word_valid & word_ready.
REQ-012 overflow  out  1  sticky: a completed word was dropped.
REQ-013 done  out  1  capture finished and FIFO drained.
REQ-014 crc_value  out  16  running CRC (macro only); crc_ok  out  1  done & crc_value==EXPECTED_CRC (macro only).

Function
REQ-015 SHALL implement FSM IDLE -> SKIP -> SHIFT -> FLUSH -> DONE.
REQ-016 IDLE: on first cycle with enable=1 go to SKIP (CHAIN_DELAY>0) or SHIFT (CHAIN_DELAY=0); that cycle counts as skip cycle 1 or payload bit 0 respectively.
REQ-017 SKIP: discard bitstream on CHAIN_DELAY enabled cycles total, then SHIFT.
REQ-018 SHIFT: sample bitstream each enabled cycle; payload bit k goes to bit (k mod 32) of word floor(k/32) (LSB first).
REQ-019 On the edge sampling bit 31 of a word, the complete word SHALL be written to the FIFO; word_valid visible from that edge.
REQ-020 After bit BITSTREAM_LENGTH-1 go to FLUSH; enable and bitstream then ignored until reset.
REQ-021 FLUSH: if BITSTREAM_LENGTH mod 32 != 0, push partial word (unfilled upper bits zero) on the first cycle FIFO is not full, then DONE; otherwise DONE immediately.
REQ-022 DONE: done=1 once FIFO empty; held until sync_reset.
REQ-023 Word completing in SHIFT with FIFO full (and no simultaneous pop) SHALL be dropped and overflow set; SHIFT never stalls.
REQ-024 Simultaneous push and pop on a full FIFO SHALL succeed with no overflow.
REQ-025 FIFO SHALL be first-in first-out; word_data stable while word_valid & !word_ready.
REQ-026 Bit and word counters SHALL wrap only by reset; no capture beyond BITSTREAM_LENGTH.

Reset
REQ-027 sync_reset SHALL return FSM to IDLE, empty FIFO, clear counters and shift register.
REQ-028 Reset values: word_valid=0, word_data=0, overflow=0, done=0, crc_value=16'hFFFF, crc_ok=0.
REQ-029 sync_reset SHALL take priority over enable, word_ready and FSM in any state, including mid-word.

Configuration
REQ-030 Macro CFG_READBACK_CRC_EN SHALL compile in CRC-16-CCITT (poly 0x1021, init 0xFFFF, no reflection, no final xor).
REQ-031 With macro: per payload bit b, fb=crc[15]^b, crc={crc[14:0],1'b0} ^ (fb?16'h1021:0); skipped bits excluded; crc_value/crc_ok ports and EXPECTED_CRC present.
REQ-032 Without macro: no CRC logic, ports or parameter; all other behaviour identical.

Verification
REQ-033 LENGTH=64, DELAY=3, ready=1: 3 junk bits then 0xDEADBEEF, 0x01234567 LSB first -> words 0xDEADBEEF then 0x01234567, done=1, overflow=0.
REQ-034 LENGTH=40, DELAY=0: 0xCAFEF00D then 0xA5 LSB first -> words 0xCAFEF00D, 0x000000A5, done=1.
REQ-035 LENGTH=128, DEPTH=2, ready=0 throughout shift: overflow=1, FIFO holds first two words; raise ready -> exactly 2 words delivered, done=1.
REQ-036 LENGTH=32, enable toggled 1,0,1,0 per cycle: word equals sent 32-bit value, completes after 64 cycles; bits during enable=0 ignored.
REQ-037 sync_reset after 17 bits, then fresh 32-bit stream 0x5A5A5A5A -> only 0x5A5A5A5A delivered, overflow=0.
REQ-038 Macro on, LENGTH=72, EXPECTED_CRC=16'h29B1, ASCII "123456789" each byte MSB first -> crc_value=16'h29B1, crc_ok=1 when done.

Source files
------------

// File: rtl/cgra_config_readback_if.sv
// rtl/cgra_config_readback_if.sv - captured-word stream between readback capture and its consumer
interface cgra_config_readback_if;
  logic [31:0] word_data;
  logic        word_valid;
  logic        word_ready;

  modport master (output word_data, output word_valid, input word_ready);
  modport slave  (input word_data, input word_valid, output word_ready);
endinterface

// File: rtl/cgra_config_readback.sv
// rtl/cgra_config_readback.sv - serial config readback capture into 32-bit words via a small FIFO
// Optional CRC-16-CCITT over payload bits when CFG_READBACK_CRC_EN is defined.
module cgra_config_readback #(
  parameter int BITSTREAM_LENGTH = 1024,
  parameter int CHAIN_DELAY      = 0,
  parameter int FIFO_DEPTH       = 4
`ifdef CFG_READBACK_CRC_EN
  , parameter logic [15:0] EXPECTED_CRC = 16'h0000
`endif
) (
  input  logic                          clock,
  input  logic                          sync_reset,
  input  logic                          enable,
  input  logic                          bitstream,
  cgra_config_readback_if.master        word_if,
  output logic                          overflow,
  output logic                          done
`ifdef CFG_READBACK_CRC_EN
  , output logic [15:0]                 crc_value,
  output logic                          crc_ok
`endif
);

  localparam int BW = $clog2(BITSTREAM_LENGTH + 1);
  localparam int SW = (CHAIN_DELAY > 0) ? $clog2(CHAIN_DELAY + 1) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam bit HAS_TAIL = (BITSTREAM_LENGTH % 32) != 0;
  localparam logic [BW-1:0] LAST_BIT  = BW'(BITSTREAM_LENGTH - 1);
  localparam logic [SW-1:0] SKIP_LAST = SW'((CHAIN_DELAY > 0) ? CHAIN_DELAY - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_SKIP, S_SHIFT, S_FLUSH, S_DONE} state_t;
  state_t state, state_next;

  logic [BW-1:0] bit_cnt;
  logic [4:0]    bit_pos;
  logic [SW-1:0] skip_cnt;
  logic [31:0]   shift_reg, shift_next, push_data;
  logic [31:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   fifo_cnt;
  logic          fifo_full, fifo_empty, pop, push, push_req;
  logic          take_bit, skip_bit, last_bit, skip_last;

  assign last_bit   = (bit_cnt == LAST_BIT);
  assign skip_last  = (skip_cnt == SKIP_LAST);
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == (AW+1)'(FIFO_DEPTH));
  assign pop        = !fifo_empty && word_if.word_ready;
  // A full FIFO still accepts a word when the head leaves on the same edge.
  assign push       = push_req && (!fifo_full || pop);

  assign word_if.word_valid = !fifo_empty;
  assign word_if.word_data  = fifo_empty ? 32'h0 : fifo_mem[rd_ptr];
  assign done               = (state == S_DONE) && fifo_empty;

  always_comb begin
    shift_next          = shift_reg;
    shift_next[bit_pos] = bitstream;
  end

  always_ff @(posedge clock) begin
    if (sync_reset) state <= S_IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    take_bit   = 1'b0;
    skip_bit   = 1'b0;
    push_req   = 1'b0;
    push_data  = shift_next;
    case (state)
      S_IDLE: if (enable) begin
        if (CHAIN_DELAY > 0) begin
          skip_bit   = 1'b1;
          state_next = skip_last ? S_SHIFT : S_SKIP;
        end else begin
          take_bit   = 1'b1;
          state_next = last_bit ? S_FLUSH : S_SHIFT;
        end
      end
      S_SKIP: if (enable) begin
        skip_bit = 1'b1;
        if (skip_last) state_next = S_SHIFT;
      end
      S_SHIFT: if (enable) begin
        take_bit = 1'b1;
        if (last_bit) state_next = S_FLUSH;
      end
      S_FLUSH: begin
        if (!HAS_TAIL) begin
          state_next = S_DONE;
        end else if (!fifo_full) begin
          push_req   = 1'b1;
          push_data  = shift_reg;
          state_next = S_DONE;
        end
      end
      default: ;
    endcase
    if (take_bit && bit_pos == 5'd31) push_req = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (sync_reset) begin
      bit_cnt   <= '0;
      bit_pos   <= '0;
      skip_cnt  <= '0;
      shift_reg <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      fifo_cnt  <= '0;
      overflow  <= 1'b0;
    end else begin
      if (skip_bit) skip_cnt <= skip_cnt + 1'b1;
      if (take_bit) begin
        bit_cnt   <= bit_cnt + 1'b1;
        bit_pos   <= bit_pos + 1'b1;
        // Clearing on word completion leaves a zero-padded partial word for the flush.
        shift_reg <= (bit_pos == 5'd31) ? 32'h0 : shift_next;
      end
      if (push) begin
        fifo_mem[wr_ptr] <= push_data;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fifo_cnt <= fifo_cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      if (push_req && !push) overflow <= 1'b1;
    end
  end

`ifdef CFG_READBACK_CRC_EN
  logic crc_fb;
  assign crc_fb = crc_value[15] ^ bitstream;

  always_ff @(posedge clock) begin
    if (sync_reset)    crc_value <= 16'hFFFF;
    else if (take_bit) crc_value <= {crc_value[14:0], 1'b0} ^ (crc_fb ? 16'h1021 : 16'h0000);
  end

  assign crc_ok = done && (crc_value == EXPECTED_CRC);
`endif

endmodule
